imem_program_loader: RTL and testbench

- Writer side of the processor's instruction-fetch path. Receives a framed byte stream, for example from the serial receiver.
- Assembles the bytes into 16-bit instruction words and writes them sequentially into instruction memory starting at address 0.
- Holds the processor in clear for the whole load. Releases it only after the frame checksum verifies.

---
 rtl/imem_program_loader.sv | 160 ++++++++++++++++
 tb/tb_imem_program_loader.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/imem_program_loader.sv
// Instruction memory program loader.
// Receives a framed byte stream (count, data words, XOR checksum), writes the
// words sequentially into instruction memory from address 0, and holds the
// processor in clear until the frame checksum verifies.
// Ports:
//   clk, clr        - clock, synchronous active-high reset
//   start           - begins a load when idle, done or in error
//   in_data/valid   - stream byte and its valid flag
//   in_ready        - loader can accept a byte (registered, state-only)
//   imem_we/addr/wdata - instruction memory write port, one pulse per word
//   cpu_hold        - processor clear request
//   done, error     - sticky completion / failure flags
module imem_program_loader #(
  parameter int unsigned ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic                  start,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [15:0]           imem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned DEPTH = 2**ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [7:0]            cnt_hi_q, cnt_hi_d;
  logic [15:0]           words_q, words_d;   // words still to be received
  logic [7:0]            chk_q, chk_d;
  logic                  in_ready_d, we_d, hold_d, done_d, error_d;
  logic [ADDR_WIDTH-1:0] addr_d;
  logic [15:0]           wdata_d;
  logic [15:0]           cnt_n;
  logic                  xfer;

  assign xfer  = in_valid && in_ready;
  assign cnt_n = {cnt_hi_q, in_data};

  // Next-state and next-register values
  always_comb begin
    state_d  = state_q;
    cnt_hi_d = cnt_hi_q;
    words_d  = words_q;
    chk_d    = chk_q;
    addr_d   = imem_addr;
    wdata_d  = imem_wdata;
    we_d     = 1'b0;
    hold_d   = cpu_hold;
    done_d   = done;
    error_d  = error;

    // Address advances in the cycle following each write pulse
    if (imem_we) addr_d = imem_addr + ADDR_WIDTH'(1);

    // Running checksum covers every transferred byte except the CHK byte
    if (xfer && (state_q != S_CHECK)) chk_d = chk_q ^ in_data;

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_CNT_HI;
          done_d  = 1'b0;
          error_d = 1'b0;
          chk_d   = 8'd0;
          addr_d  = '0;
          words_d = 16'd0;
          hold_d  = 1'b1;
        end
      end
      S_CNT_HI: begin
        if (xfer) begin
          cnt_hi_d = in_data;
          state_d  = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (xfer) begin
          words_d = cnt_n;
          if (cnt_n == 16'd0) begin
            state_d = S_CHECK;
          end else if (32'(cnt_n) > DEPTH) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA_HI;
          end
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          wdata_d[15:8] = in_data;
          state_d       = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          wdata_d[7:0] = in_data;
          we_d         = 1'b1;
          words_d      = words_q - 16'd1;
          state_d      = (words_q == 16'd1) ? S_CHECK : S_DATA_HI;
        end
      end
      S_CHECK: begin
        if (xfer) begin
          if (in_data == chk_q) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            hold_d  = 1'b0;
          end else begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    in_ready_d = (state_d inside {S_CNT_HI, S_CNT_LO, S_DATA_HI, S_DATA_LO, S_CHECK});
  end

  // State and output registers
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q    <= S_IDLE;
      cnt_hi_q   <= 8'd0;
      words_q    <= 16'd0;
      chk_q      <= 8'd0;
      in_ready   <= 1'b0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= 16'd0;
      cpu_hold   <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_hi_q   <= cnt_hi_d;
      words_q    <= words_d;
      chk_q      <= chk_d;
      in_ready   <= in_ready_d;
      imem_we    <= we_d;
      imem_addr  <= addr_d;
      imem_wdata <= wdata_d;
      cpu_hold   <= hold_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

endmodule

// File: tb/tb_imem_program_loader.sv
// Testbench for imem_program_loader: frame-level reference model, write
// scoreboard checked every cycle, and directed plus randomized frames.
module tb_imem_program_loader;

  localparam int unsigned AW    = 8;
  localparam int unsigned DEPTH = 2**AW;

  typedef logic [7:0] byte_q_t[$];
  typedef struct {
    int addr;
    int data;
  } wr_t;

  logic          clk = 1'b0;
  logic          clr;
  logic          start;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [15:0]   imem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          error;

  int   tests = 0;
  int   fails = 0;
  wr_t  exp_q[$];
  wr_t  cmp_w;
  logic [15:0] mirror [DEPTH];

  always #5 clk = ~clk;

  imem_program_loader #(.ADDR_WIDTH(AW)) dut (
    .clk(clk), .clr(clr), .start(start), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .imem_we(imem_we), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .cpu_hold(cpu_hold), .done(done), .error(error)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Every write strobe must match the next write the model predicts
  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_we", 32'd1, 32'd0);
      end else begin
        cmp_w = exp_q.pop_front();
        check("we_addr", 32'(imem_addr), 32'(cmp_w.addr));
        check("we_data", 32'(imem_wdata), 32'(cmp_w.data));
      end
      mirror[imem_addr] = imem_wdata;
    end
  end

  // Builds a frame of n random words; bad_chk corrupts the checksum byte
  function automatic byte_q_t make_frame(input int n, input bit bad_chk);
    byte_q_t    f;
    logic [7:0] x;
    f.push_back(8'(n >> 8));
    f.push_back(8'(n));
    for (int i = 0; i < 2*n; i++) f.push_back(8'($urandom));
    x = 8'd0;
    foreach (f[i]) x ^= f[i];
    f.push_back(bad_chk ? ~x : x);
    return f;
  endfunction

  task automatic do_start();
    @(negedge clk);
    start    = 1'b1;
    in_valid = 1'b0;
  endtask

  // Streams the bytes with optional random bubbles and stray start pulses
  task automatic send_bytes(input byte_q_t f, input int bub, input int stp);
    int i     = 0;
    int guard = 0;
    while (i < f.size()) begin
      @(negedge clk);
      in_valid = ($urandom_range(99) >= bub);
      in_data  = in_valid ? f[i] : 8'($urandom);
      start    = ($urandom_range(99) < stp);
      if (in_valid && in_ready) begin
        if (i == f.size() - 1) check("hold_during_load", 32'(cpu_hold), 32'd1);
        i++;
        guard = 0;
      end else begin
        guard++;
        if (guard > 2000) begin
          check("byte_timeout", 32'(i), 32'(f.size()));
          break;
        end
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    start    = 1'b0;
  endtask

  // Frame-level model: predicts writes and final status, then runs the frame
  task automatic run_frame(input string tag, input byte_q_t f, input int bub,
                           input int stp, input bit issue_start);
    logic [15:0] n;
    logic [7:0]  x;
    bit          good;
    wr_t         w;
    n    = {f[0], f[1]};
    good = 1'b0;
    if (32'(n) <= DEPTH) begin
      for (int i = 0; i < int'(n); i++) begin
        w.addr = i;
        w.data = int'({f[2+2*i], f[3+2*i]});
        exp_q.push_back(w);
      end
      x = 8'd0;
      for (int i = 0; i < f.size() - 1; i++) x ^= f[i];
      good = (x == f[f.size()-1]);
    end
    if (issue_start) do_start();
    send_bytes(f, bub, stp);
    check({tag, "_done"}, 32'(done), 32'(good));
    check({tag, "_error"}, 32'(error), 32'(!good));
    check({tag, "_cpu_hold"}, 32'(cpu_hold), 32'(!good));
    check({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    check({tag, "_writes_left"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    byte_q_t f;
    byte_q_t g;
    clr = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;
    repeat (3) @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_imem_we", 32'(imem_we), 32'd0);
    check("rst_imem_addr", 32'(imem_addr), 32'd0);
    check("rst_imem_wdata", 32'(imem_wdata), 32'd0);
    check("rst_cpu_hold", 32'(cpu_hold), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_error", 32'(error), 32'd0);
    clr = 1'b0;

    // Good load with hand-known contents
    g = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    run_frame("good", g, 0, 0, 1'b1);
    check("good_mem0", 32'(mirror[0]), 32'h1234);
    check("good_mem1", 32'(mirror[1]), 32'hABCD);

    // start and a byte together in DONE: byte must not be taken
    @(negedge clk);
    start = 1'b1; in_valid = 1'b1; in_data = 8'h55;
    check("done_start_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    start = 1'b0; in_valid = 1'b0;
    run_frame("after_start", g, 0, 0, 1'b0);

    // Bad checksum, then recovery
    f = '{8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    run_frame("badchk", f, 0, 0, 1'b1);
    check("badchk_mem1", 32'(mirror[1]), 32'hABCD);
    run_frame("recover", g, 0, 0, 1'b1);

    // Zero count and overflow
    f = '{8'h00, 8'h00, 8'h00};
    run_frame("zero", f, 0, 0, 1'b1);
    f = '{8'h01, 8'h01};
    run_frame("ovf", f, 0, 0, 1'b1);

    // Same 4-word frame without and with bubbles / stray starts
    f = make_frame(4, 1'b0);
    run_frame("nobubble", f, 0, 0, 1'b1);
    run_frame("bubble", f, 40, 15, 1'b1);

    // Reset after the second data byte
    do_start();
    w_push(0, 16'h1122);
    f = '{8'h00, 8'h04, 8'h11, 8'h22};
    send_bytes(f, 0, 0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    check("clr_in_ready", 32'(in_ready), 32'd0);
    check("clr_cpu_hold", 32'(cpu_hold), 32'd0);
    check("clr_imem_addr", 32'(imem_addr), 32'd0);
    check("clr_done", 32'(done), 32'd0);
    check("clr_writes_left", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    run_frame("post_clr", g, 0, 0, 1'b1);

    // Full-depth frame: last write lands at depth-1, address wraps
    f = make_frame(DEPTH, 1'b0);
    run_frame("full", f, 0, 0, 1'b1);
    check("full_last_word", 32'(mirror[DEPTH-1]), 32'({f[2*DEPTH], f[2*DEPTH+1]}));
    check("full_addr_wrap", 32'(imem_addr), 32'd0);

    // Randomized frames
    for (int k = 0; k < 12; k++) begin
      f = make_frame(int'($urandom_range(8, 1)), ($urandom_range(1) == 1));
      run_frame("rand", f, 30, 10, 1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  task automatic w_push(input int a, input logic [15:0] d);
    wr_t w;
    w.addr = a;
    w.data = int'(d);
    exp_q.push_back(w);
  endtask

endmodule
